// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush/bubble insertion (selectively kept fields)
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned               DATA_W     = 32,
    parameter int unsigned               NUM_FIELDS = 6,
    parameter logic [NUM_FIELDS-1:0]     KEEP_MASK  = '0,
    parameter int unsigned               CNT_W      = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         cnt_clr_i,
    input  logic                         valid_i,
    input  logic [NUM_FIELDS*DATA_W-1:0] data_i,
    output logic                         valid_o,
    output logic [NUM_FIELDS*DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic [CNT_W-1:0]             bubble_cnt_o
);

    localparam int unsigned PAYLOAD_W = NUM_FIELDS * DATA_W;

    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
    logic [PAYLOAD_W-1:0] keep_bits;

    // Expand the per-field keep mask to a per-bit mask over the payload.
    always_comb begin
        keep_bits = '0;
        for (int k = 0; k < int'(NUM_FIELDS); k++) begin
            keep_bits[k*DATA_W +: DATA_W] = {DATA_W{KEEP_MASK[k]}};
        end
    end

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_i) begin
            data_d  = data_i & keep_bits;
            valid_d = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (stall_i) begin
            // Only stalls of a real instruction are counted; frozen bubbles are free.
            if (valid_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            data_d  = data_i;
            valid_d = valid_i;
        end

        if (cnt_clr_i) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule
